// File: rtl/uart_buffer_pkg.sv
// ----------------------------------------------------------------------------
// uart_buffer_pkg
// Shared definitions for the buffered UART front-end:
//   - register byte offsets inside the UART slot (DATA / STATUS / CTRL)
//   - STATUS and CTRL bit positions
//   - TX and RX handshake FSM state encodings
// ----------------------------------------------------------------------------
package uart_buffer_pkg;

   localparam logic [3:0] ADDR_DATA   = 4'h0;
   localparam logic [3:0] ADDR_STATUS = 4'h4;
   localparam logic [3:0] ADDR_CTRL   = 4'h8;

   // STATUS register layout
   localparam int ST_TX_FULL    = 0;
   localparam int ST_RX_AVAIL   = 1;
   localparam int ST_TX_DONE    = 2;
   localparam int ST_RX_OVF     = 3;
   localparam int ST_TX_OVF     = 4;
   localparam int ST_RX_CNT_LSB = 8;
   localparam int ST_TX_CNT_LSB = 16;

   // CTRL register layout (only meaningful with UART_BUF_IRQ_EN)
   localparam int CTRL_RX_IE = 0;
   localparam int CTRL_TX_IE = 1;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_STROBE,
      TX_SETTLE,
      TX_DRAIN
   } tx_state_t;

   typedef enum logic {
      RX_WAIT,
      RX_RELEASE
   } rx_state_t;

endpackage

// File: rtl/uart_buffer_sync_fifo.sv
// ----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with a show-ahead head (o_head is the oldest entry while
// not empty). A push on a full FIFO is accepted when a pop happens in the
// same cycle, so a full FIFO can stream without losing a slot.
// Ports:
//   clk, reset_i (async, active-low) - clock / reset of pointers and count
//   i_push, i_data                   - write request and data
//   i_pop                            - read request (ignored when empty)
//   o_head                           - oldest stored entry
//   o_full, o_empty, o_count         - occupancy ($clog2(DEPTH)+1 bits)
// ----------------------------------------------------------------------------
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     reset_i,
   input  logic                     i_push,
   input  logic                     i_pop,
   input  logic [WIDTH-1:0]         i_data,
   output logic [WIDTH-1:0]         o_head,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [CW-1:0]    r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_full    = (r_count == CW'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;
   assign o_head    = r_mem[r_rptr];

   assign w_do_pop  = i_pop & ~o_empty;
   assign w_do_push = i_push & (~o_full | w_do_pop);

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge reset_i) begin
      if (!reset_i) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_do_push) r_wptr <= r_wptr + 1'b1;
         if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage carries no reset; validity is tracked by the pointers.
   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wptr] <= i_data;
   end

endmodule

// File: rtl/uart_buffer.sv
// ----------------------------------------------------------------------------
// uart_buffer
// Buffered UART front-end between the SoC peripheral decoder and the uart
// core. CPU writes to DATA queue into a TX FIFO that an FSM drains into the
// core; bytes offered by the core are acknowledged into an RX FIFO.
// Optional feature macro: UART_BUF_IRQ_EN (adds CTRL register and irq_o).
// Ports:
//   clk, reset_i (async, active-low)
//   sel_i, we_i, addr_i[3:0], data_i[31:0]  - CPU access (0x0 DATA, 0x4 STATUS, 0x8 CTRL)
//   data_o[31:0]                            - CPU read data (combinational)
//   uart_wr_o, uart_tx_data_o[7:0]          - 1-cycle TX strobe + byte to the core
//   uart_busy_i                             - core is transmitting
//   uart_rd_o                               - 1-cycle RX acknowledge to the core
//   uart_rx_data_i[7:0], uart_valid_i       - core RX byte / byte pending
//   irq_o                                   - interrupt (UART_BUF_IRQ_EN only)
// ----------------------------------------------------------------------------
module uart_buffer
   import uart_buffer_pkg::*;
#(
   parameter int TX_DEPTH = 16,
   parameter int RX_DEPTH = 16
) (
   input  logic        clk,
   input  logic        reset_i,
   input  logic        sel_i,
   input  logic        we_i,
   input  logic [3:0]  addr_i,
   input  logic [31:0] data_i,
   output logic [31:0] data_o,
   output logic        uart_wr_o,
   output logic [7:0]  uart_tx_data_o,
   input  logic        uart_busy_i,
   output logic        uart_rd_o,
   input  logic [7:0]  uart_rx_data_i,
   input  logic        uart_valid_i
`ifdef UART_BUF_IRQ_EN
   ,
   output logic        irq_o
`endif
);

   localparam int TX_CW = $clog2(TX_DEPTH) + 1;
   localparam int RX_CW = $clog2(RX_DEPTH) + 1;

   // CPU access decode
   logic r_acc_q;
   logic w_acc;
   logic w_acc_edge;
   logic w_st_wr;
   logic w_rd;

   // TX path
   tx_state_t        r_tx_state;
   tx_state_t        w_tx_next;
   logic             r_settle_cnt;
   logic             w_tx_wr_req;
   logic             w_tx_push;
   logic             w_tx_pop;
   logic             w_tx_drop;
   logic [7:0]       w_tx_head;
   logic             w_tx_full;
   logic             w_tx_empty;
   logic [TX_CW-1:0] w_tx_count;
   logic             w_tx_idle;

   // RX path
   rx_state_t        r_rx_state;
   rx_state_t        w_rx_next;
   logic             w_rx_req;
   logic             w_rx_push;
   logic             w_rx_pop;
   logic             w_rx_drop;
   logic [7:0]       w_rx_head;
   logic             w_rx_full;
   logic             w_rx_empty;
   logic [RX_CW-1:0] w_rx_count;

   // Sticky flags and read-back
   logic             r_rx_ovf;
   logic             r_tx_ovf;
   logic [31:0]      w_status;
   logic             w_unused_data;

   assign w_unused_data = ^data_i[31:8];

   // A DATA access only acts on its first cycle so a held address moves one byte.
   assign w_acc      = sel_i & (addr_i == ADDR_DATA);
   assign w_acc_edge = w_acc & ~r_acc_q;
   assign w_st_wr    = sel_i & we_i & (addr_i == ADDR_STATUS);
   assign w_rd       = reset_i & sel_i & ~we_i;

   always_ff @(posedge clk or negedge reset_i) begin
      if (!reset_i) r_acc_q <= 1'b0;
      else          r_acc_q <= w_acc;
   end

   // TX FIFO: a full FIFO still accepts a byte when the drain pops this cycle.
   assign w_tx_idle   = (r_tx_state == TX_IDLE);
   assign w_tx_pop    = (r_tx_state == TX_STROBE);
   assign w_tx_wr_req = w_acc_edge & we_i;
   assign w_tx_push   = w_tx_wr_req & (~w_tx_full | w_tx_pop);
   assign w_tx_drop   = w_tx_wr_req & w_tx_full & ~w_tx_pop;

   sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
      .clk     (clk),
      .reset_i (reset_i),
      .i_push  (w_tx_push),
      .i_pop   (w_tx_pop),
      .i_data  (data_i[7:0]),
      .o_head  (w_tx_head),
      .o_full  (w_tx_full),
      .o_empty (w_tx_empty),
      .o_count (w_tx_count)
   );

   // RX FIFO: the core is acked even when the byte has to be dropped.
   assign w_rx_req  = (r_rx_state == RX_WAIT) & uart_valid_i;
   assign w_rx_pop  = w_acc_edge & ~we_i & ~w_rx_empty;
   assign w_rx_push = w_rx_req & (~w_rx_full | w_rx_pop);
   assign w_rx_drop = w_rx_req & w_rx_full & ~w_rx_pop;

   sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
      .clk     (clk),
      .reset_i (reset_i),
      .i_push  (w_rx_push),
      .i_pop   (w_rx_pop),
      .i_data  (uart_rx_data_i),
      .o_head  (w_rx_head),
      .o_full  (w_rx_full),
      .o_empty (w_rx_empty),
      .o_count (w_rx_count)
   );

   // Overflow flags: W1C, a same-cycle set takes priority over the clear.
   always_ff @(posedge clk or negedge reset_i) begin
      if (!reset_i) begin
         r_rx_ovf <= 1'b0;
         r_tx_ovf <= 1'b0;
      end else begin
         r_rx_ovf <= w_rx_drop | (r_rx_ovf & ~(w_st_wr & data_i[ST_RX_OVF]));
         r_tx_ovf <= w_tx_drop | (r_tx_ovf & ~(w_st_wr & data_i[ST_TX_OVF]));
      end
   end

   // TX FSM state register; SETTLE lasts two cycles via r_settle_cnt.
   always_ff @(posedge clk or negedge reset_i) begin
      if (!reset_i) begin
         r_tx_state   <= TX_IDLE;
         r_settle_cnt <= 1'b0;
      end else begin
         r_tx_state   <= w_tx_next;
         r_settle_cnt <= (r_tx_state == TX_SETTLE) ? ~r_settle_cnt : 1'b0;
      end
   end

   // SETTLE ignores busy: the core raises it a cycle after seeing the strobe.
   always_comb begin
      w_tx_next      = r_tx_state;
      uart_wr_o      = 1'b0;
      uart_tx_data_o = 8'd0;
      case (r_tx_state)
         TX_IDLE:   if (!w_tx_empty && !uart_busy_i) w_tx_next = TX_STROBE;
         TX_STROBE: begin
            uart_wr_o      = 1'b1;
            uart_tx_data_o = w_tx_head;
            w_tx_next      = TX_SETTLE;
         end
         TX_SETTLE: if (r_settle_cnt) w_tx_next = TX_DRAIN;
         TX_DRAIN:  if (!uart_busy_i) w_tx_next = TX_IDLE;
         default:   w_tx_next = TX_IDLE;
      endcase
   end

   // RX FSM: one byte per assertion of uart_valid_i.
   always_ff @(posedge clk or negedge reset_i) begin
      if (!reset_i) r_rx_state <= RX_WAIT;
      else          r_rx_state <= w_rx_next;
   end

   always_comb begin
      w_rx_next = r_rx_state;
      uart_rd_o = 1'b0;
      case (r_rx_state)
         RX_WAIT: begin
            if (uart_valid_i) begin
               uart_rd_o = reset_i;
               w_rx_next = RX_RELEASE;
            end
         end
         RX_RELEASE: if (!uart_valid_i) w_rx_next = RX_WAIT;
         default:    w_rx_next = RX_WAIT;
      endcase
   end

   always_comb begin
      w_status                         = 32'd0;
      w_status[ST_TX_FULL]             = w_tx_full;
      w_status[ST_RX_AVAIL]            = ~w_rx_empty;
      w_status[ST_TX_DONE]             = w_tx_empty & w_tx_idle;
      w_status[ST_RX_OVF]              = r_rx_ovf;
      w_status[ST_TX_OVF]              = r_tx_ovf;
      w_status[ST_RX_CNT_LSB +: 8]     = 8'(w_rx_count);
      w_status[ST_TX_CNT_LSB +: 8]     = 8'(w_tx_count);
   end

`ifdef UART_BUF_IRQ_EN
   logic [1:0] r_ctrl;
   logic       r_irq;

   always_ff @(posedge clk or negedge reset_i) begin
      if (!reset_i) begin
         r_ctrl <= 2'b00;
         r_irq  <= 1'b0;
      end else begin
         if (sel_i && we_i && (addr_i == ADDR_CTRL)) r_ctrl <= data_i[1:0];
         r_irq <= (r_ctrl[CTRL_RX_IE] & ~w_rx_empty) |
                  (r_ctrl[CTRL_TX_IE] & w_tx_empty & w_tx_idle);
      end
   end

   assign irq_o = r_irq;
`endif

   // Read mux; an empty RX FIFO reads as zero rather than a stale head.
   always_comb begin
      data_o = 32'd0;
      if (w_rd) begin
         case (addr_i)
            ADDR_DATA:   data_o = {23'd0, ~w_rx_empty, w_rx_head & {8{~w_rx_empty}}};
            ADDR_STATUS: data_o = w_status;
`ifdef UART_BUF_IRQ_EN
            ADDR_CTRL:   data_o = {30'd0, r_ctrl};
`endif
            default:     data_o = 32'd0;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_buffer.sv
module tb_uart_buffer;

   localparam int TX_D = 16;
   localparam int RX_D = 16;

   logic        clk = 1'b0;
   logic        reset_i;
   logic        sel_i, we_i;
   logic [3:0]  addr_i;
   logic [31:0] data_i;
   logic [31:0] data_o;
   logic        uart_wr_o;
   logic [7:0]  uart_tx_data_o;
   logic        core_busy, force_busy;
   logic        uart_busy_i;
   logic        uart_rd_o;
   logic [7:0]  uart_rx_data_i;
   logic        uart_valid_i;
`ifdef UART_BUF_IRQ_EN
   logic        irq_o;
`endif

   int total = 0;
   int bad   = 0;
   int wr_count = 0;
   int rd_count = 0;
   int rx_model_cnt = 0;
   logic [7:0] tx_exp[$];
   logic [7:0] rx_exp[$];
   logic [7:0] m_exp;

   assign uart_busy_i = core_busy | force_busy;

   uart_buffer #(.TX_DEPTH(TX_D), .RX_DEPTH(RX_D)) dut (
      .clk            (clk),
      .reset_i        (reset_i),
      .sel_i          (sel_i),
      .we_i           (we_i),
      .addr_i         (addr_i),
      .data_i         (data_i),
      .data_o         (data_o),
      .uart_wr_o      (uart_wr_o),
      .uart_tx_data_o (uart_tx_data_o),
      .uart_busy_i    (uart_busy_i),
      .uart_rd_o      (uart_rd_o),
      .uart_rx_data_i (uart_rx_data_i),
      .uart_valid_i   (uart_valid_i)
`ifdef UART_BUF_IRQ_EN
      ,
      .irq_o          (irq_o)
`endif
   );

   always #5 clk = ~clk;

   // TX scoreboard consumer and RX ack counter, sampled on the falling edge.
   initial begin
      forever begin
         @(negedge clk);
         if (uart_wr_o === 1'b1) begin
            wr_count++;
            total++;
            if (tx_exp.size() == 0) begin
               bad++;
               $display("FAIL tx_unexpected: strobe with data=%02h, required no strobe", uart_tx_data_o);
            end else begin
               m_exp = tx_exp.pop_front();
               if (uart_tx_data_o !== m_exp) begin
                  bad++;
                  $display("FAIL tx_data: got %02h, required %02h", uart_tx_data_o, m_exp);
               end
            end
            total++;
            if (uart_busy_i !== 1'b0) begin
               bad++;
               $display("FAIL tx_while_busy: busy=%b at strobe, required 0", uart_busy_i);
            end
         end
         if (uart_rd_o === 1'b1) rd_count++;
      end
   end

   // Core model: goes busy one cycle after a strobe, for six cycles.
   initial begin
      core_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (uart_wr_o === 1'b1) begin
            @(posedge clk); #2;
            core_busy = 1'b1;
            repeat (6) @(posedge clk);
            #2;
            core_busy = 1'b0;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic cpu_write(input logic [3:0] a, input logic [31:0] d);
      sel_i = 1'b1; we_i = 1'b1; addr_i = a; data_i = d;
      cyc(1);
      sel_i = 1'b0; we_i = 1'b0; addr_i = 4'h0; data_i = 32'd0;
      cyc(1);
   endtask

   task automatic cpu_read(input logic [3:0] a, input int hold, output logic [31:0] v);
      sel_i = 1'b1; we_i = 1'b0; addr_i = a;
      #1;
      v = data_o;
      cyc(hold);
      sel_i = 1'b0; addr_i = 4'h0;
      cyc(1);
   endtask

   task automatic rx_byte(input logic [7:0] b, input int hold);
      uart_rx_data_i = b;
      uart_valid_i   = 1'b1;
      if (rx_model_cnt < RX_D) begin
         rx_exp.push_back(b);
         rx_model_cnt++;
      end
      cyc(hold);
      uart_valid_i = 1'b0;
      cyc(2);
   endtask

   task automatic wait_tx_drain(input string name, input int bound);
      for (int i = 0; i < bound && tx_exp.size() != 0; i++) @(posedge clk);
      #2;
      total++;
      if (tx_exp.size() != 0) begin
         bad++;
         $display("FAIL %s: %0d bytes still pending, required 0", name, tx_exp.size());
         tx_exp.delete();
      end
   endtask

   task automatic test_reset();
      logic [31:0] v;
      #1;
      total++;
      if ({uart_wr_o, uart_tx_data_o, uart_rd_o, data_o} !== '0) begin
         bad++;
         $display("FAIL reset_outputs: wr=%b tx=%02h rd=%b data=%08h, required all 0",
                  uart_wr_o, uart_tx_data_o, uart_rd_o, data_o);
      end
`ifdef UART_BUF_IRQ_EN
      total++;
      if (irq_o !== 1'b0) begin bad++; $display("FAIL reset_irq: got %b, required 0", irq_o); end
`endif
      cyc(3);
      reset_i = 1'b1;
      cyc(1);
      cpu_read(4'h4, 1, v);
      total++;
      if (v !== 32'h0000_0004) begin bad++; $display("FAIL reset_status: got %08h, required %08h", v, 32'h4); end
   endtask

   task automatic test_tx_basic();
      logic [31:0] v;
      int w0;
      logic [7:0] msg[3];
      msg[0] = 8'h41; msg[1] = 8'h42; msg[2] = 8'h43;
      w0 = wr_count;
      force_busy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tx_exp.push_back(msg[i]);
         cpu_write(4'h0, {24'd0, msg[i]});
      end
      wait_tx_drain("tx_basic_drain", 500);
      cyc(20);
      total++;
      if (wr_count - w0 != 3) begin bad++; $display("FAIL tx_basic_count: got %0d strobes, required 3", wr_count - w0); end
      cpu_read(4'h4, 1, v);
      total++;
      if (v !== 32'h0000_0004) begin bad++; $display("FAIL tx_basic_status: got %08h, required %08h", v, 32'h4); end
   endtask

   task automatic test_tx_overflow();
      logic [31:0] v;
      force_busy = 1'b1;
      for (int i = 0; i < TX_D + 1; i++) begin
         if (i < TX_D) tx_exp.push_back(8'h60 + 8'(i));
         cpu_write(4'h0, 32'h60 + 32'(i));
      end
      cpu_read(4'h4, 1, v);
      total++;
      if (v !== 32'h0010_0011) begin bad++; $display("FAIL tx_ovf_status: got %08h, required %08h", v, 32'h0010_0011); end
      cpu_write(4'h4, 32'h10);
      cpu_read(4'h4, 1, v);
      total++;
      if (v !== 32'h0010_0001) begin bad++; $display("FAIL tx_ovf_clear: got %08h, required %08h", v, 32'h0010_0001); end
      force_busy = 1'b0;
      wait_tx_drain("tx_ovf_drain", 3000);
      cyc(20);
      cpu_read(4'h4, 1, v);
      total++;
      if (v !== 32'h0000_0004) begin bad++; $display("FAIL tx_ovf_final: got %08h, required %08h", v, 32'h4); end
   endtask

   task automatic test_rx_single();
      logic [31:0] v;
      int r0;
      r0 = rd_count;
      rx_byte(8'h5A, 10);
      total++;
      if (rd_count - r0 != 1) begin bad++; $display("FAIL rx_single_acks: got %0d, required 1", rd_count - r0); end
      cpu_read(4'h4, 1, v);
      total++;
      if (v !== 32'h0000_0106) begin bad++; $display("FAIL rx_single_status: got %08h, required %08h", v, 32'h106); end
      cpu_read(4'h0, 3, v);
      m_exp = rx_exp.pop_front();
      rx_model_cnt--;
      total++;
      if (v !== {23'd0, 1'b1, m_exp}) begin bad++; $display("FAIL rx_single_data: got %08h, required %08h", v, {23'd0, 1'b1, m_exp}); end
      cpu_read(4'h4, 1, v);
      total++;
      if (v !== 32'h0000_0004) begin bad++; $display("FAIL rx_single_popped: got %08h, required %08h", v, 32'h4); end
      cpu_read(4'h0, 1, v);
      total++;
      if (v !== 32'h0) begin bad++; $display("FAIL rx_empty_read: got %08h, required 0", v); end
   endtask

   task automatic test_rx_overflow();
      logic [31:0] v;
      int r0;
      r0 = rd_count;
      for (int i = 0; i < RX_D + 1; i++) rx_byte(8'hA0 + 8'(i), 2);
      total++;
      if (rd_count - r0 != RX_D + 1) begin bad++; $display("FAIL rx_ovf_acks: got %0d, required %0d", rd_count - r0, RX_D + 1); end
      cpu_read(4'h4, 1, v);
      total++;
      if (v !== 32'h0000_100E) begin bad++; $display("FAIL rx_ovf_status: got %08h, required %08h", v, 32'h100E); end
      for (int i = 0; i < RX_D; i++) begin
         cpu_read(4'h0, 1, v);
         m_exp = (rx_exp.size() != 0) ? rx_exp.pop_front() : 8'h00;
         rx_model_cnt--;
         total++;
         if (v !== {23'd0, 1'b1, m_exp}) begin bad++; $display("FAIL rx_ovf_data[%0d]: got %08h, required %08h", i, v, {23'd0, 1'b1, m_exp}); end
      end
      cpu_write(4'h4, 32'h08);
      cpu_read(4'h4, 1, v);
      total++;
      if (v !== 32'h0000_0004) begin bad++; $display("FAIL rx_ovf_clear: got %08h, required %08h", v, 32'h4); end
   endtask

   task automatic test_reset_midframe();
      logic [31:0] v;
      int w0;
      bit seen;
      force_busy = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tx_exp.push_back(8'h70 + 8'(i));
         cpu_write(4'h0, 32'h70 + 32'(i));
      end
      force_busy = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 50 && !seen; i++) begin
         cyc(1);
         if (uart_wr_o === 1'b1) seen = 1'b1;
      end
      total++;
      if (!seen) begin bad++; $display("FAIL midframe_strobe: no strobe within 50 cycles, required one"); end
      cyc(1);
      reset_i = 1'b0;
      #1;
      tx_exp.delete();
      total++;
      if ({uart_wr_o, uart_tx_data_o, uart_rd_o, data_o} !== '0) begin
         bad++;
         $display("FAIL midframe_outputs: wr=%b tx=%02h rd=%b data=%08h, required all 0",
                  uart_wr_o, uart_tx_data_o, uart_rd_o, data_o);
      end
      cyc(3);
      reset_i = 1'b1;
      cyc(1);
      w0 = wr_count;
      cpu_read(4'h4, 1, v);
      total++;
      if (v !== 32'h0000_0004) begin bad++; $display("FAIL midframe_status: got %08h, required %08h", v, 32'h4); end
      cyc(40);
      total++;
      if (wr_count != w0) begin bad++; $display("FAIL midframe_no_tx: got %0d strobes, required 0", wr_count - w0); end
   endtask

`ifdef UART_BUF_IRQ_EN
   task automatic test_irq();
      logic [31:0] v;
      cpu_write(4'h8, 32'h1);
      cpu_read(4'h8, 1, v);
      total++;
      if (v !== 32'h1) begin bad++; $display("FAIL irq_ctrl: got %08h, required 1", v); end
      uart_rx_data_i = 8'h33;
      uart_valid_i   = 1'b1;
      rx_exp.push_back(8'h33);
      rx_model_cnt++;
      cyc(1);
      total++;
      if (irq_o !== 1'b0) begin bad++; $display("FAIL irq_early: got %b, required 0", irq_o); end
      cyc(1);
      total++;
      if (irq_o !== 1'b1) begin bad++; $display("FAIL irq_set: got %b, required 1", irq_o); end
      uart_valid_i = 1'b0;
      cyc(2);
      sel_i = 1'b1; we_i = 1'b0; addr_i = 4'h0;
      #1;
      v = data_o;
      m_exp = rx_exp.pop_front();
      rx_model_cnt--;
      total++;
      if (v !== {23'd0, 1'b1, m_exp}) begin bad++; $display("FAIL irq_data: got %08h, required %08h", v, {23'd0, 1'b1, m_exp}); end
      cyc(1);
      total++;
      if (irq_o !== 1'b1) begin bad++; $display("FAIL irq_hold: got %b, required 1", irq_o); end
      cyc(1);
      total++;
      if (irq_o !== 1'b0) begin bad++; $display("FAIL irq_clear: got %b, required 0", irq_o); end
      sel_i = 1'b0;
      cyc(1);
      cpu_write(4'h8, 32'h0);
   endtask
`endif

   initial begin
      reset_i = 1'b0; sel_i = 1'b0; we_i = 1'b0; addr_i = 4'h0; data_i = 32'd0;
      force_busy = 1'b0; uart_rx_data_i = 8'h00; uart_valid_i = 1'b0;
      test_reset();
      test_tx_basic();
      test_tx_overflow();
      test_rx_single();
      test_rx_overflow();
`ifdef UART_BUF_IRQ_EN
      test_irq();
`endif
      test_reset_midframe();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
